// File: rtl/register_file_pkg.sv
// Shared definitions for the CPU register bank: default geometry, the
// byte-lane helper, and symbolic register indices used by decode and the
// address unit.
package register_file_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_AW    = 3;

    // Number of 8-bit lanes in a word of the given width.
    function automatic int byte_lanes(input int width);
        return width / 8;
    endfunction

    // Architectural register names; decode and the address unit refer to
    // these rather than raw numbers.
    typedef enum logic [2:0] {
        REG_ZERO = 3'd0,
        REG_A    = 3'd1,
        REG_B    = 3'd2,
        REG_C    = 3'd3,
        REG_D    = 3'd4,
        REG_BP   = 3'd5,
        REG_IX   = 3'd6,
        REG_SP   = 3'd7
    } reg_index_e;

endpackage

// File: rtl/register_file_word.sv
// One storage word of the register bank. Holds the byte-lane write merge,
// the +/- STEP adder, and the rule that a write always beats an increment
// aimed at the same word. Selection, range and hardwired-zero checks are
// done by the parent, so wr_en/inc_en arrive already qualified.
module register_file_word
    import register_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [byte_lanes(WIDTH)-1:0] wr_be,
    input  logic                         inc_en,
    input  logic                         inc_down,
    output logic [WIDTH-1:0]             value
);

    localparam int LANES = byte_lanes(WIDTH);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] be_mask;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] word_q;

    // Expand the per-byte enables into a bit mask for the merge.
    always_comb begin
        be_mask = '0;
        for (int b = 0; b < LANES; b++) begin
            be_mask[8*b +: 8] = {8{wr_be[b]}};
        end
    end

    assign merged  = (wr_data & be_mask) | (word_q & ~be_mask);
    assign stepped = inc_down ? (word_q - STEP_W) : (word_q + STEP_W);

    // Write has priority; a colliding increment is dropped for every byte,
    // not only the enabled ones.
    always_comb begin
        word_d = word_q;
        if (wr_en) begin
            word_d = merged;
        end else if (inc_en) begin
            word_d = stepped;
        end
    end

    // Storage flop with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign value = word_q;

endmodule

// File: rtl/register_file.sv
// CPU register bank: DEPTH words of WIDTH bits, one byte-enabled write
// port, two combinational read ports with optional write forwarding, and an
// increment/decrement port for pointer registers. Address decode, range
// checks, the optional hardwired zero register and the bypass live here;
// the per-word storage lives in register_file_word.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int STEP     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic [byte_lanes(WIDTH)-1:0] wbe,
    input  logic [AW-1:0]                raddr_a,
    output logic [WIDTH-1:0]             rdata_a,
    input  logic [AW-1:0]                raddr_b,
    output logic [WIDTH-1:0]             rdata_b,
    input  logic                         inc_en,
    input  logic [AW-1:0]                inc_addr,
    input  logic                         inc_down,
    output logic [WIDTH-1:0]             inc_old
);

    localparam int LANES = byte_lanes(WIDTH);

    logic [WIDTH-1:0] words [DEPTH];
    logic [WIDTH-1:0] be_mask;
    logic [WIDTH-1:0] old_w;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;
    logic             write_ok;
    logic             bypass_a;
    logic             bypass_b;

    // One storage word per register; a hardwired zero register gets no
    // storage at all, so writes and increments to it vanish naturally.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (ZERO_REG != 0 && i == 0) begin : g_zero
            assign words[i] = '0;
        end else begin : g_store
            logic wr_sel;
            logic inc_sel;

            assign wr_sel  = we && (waddr == AW'(i));
            assign inc_sel = inc_en && (inc_addr == AW'(i));

            register_file_word #(
                .WIDTH (WIDTH),
                .STEP  (STEP)
            ) u_word (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (wr_sel),
                .wr_data  (wdata),
                .wr_be    (wbe),
                .inc_en   (inc_sel),
                .inc_down (inc_down),
                .value    (words[i])
            );
        end
    end

    // Read muxes built as compare-and-select so out-of-range or unused
    // address codes return zero instead of indexing past the array.
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        inc_old  = '0;
        old_w    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) begin
                stored_a = words[i];
            end
            if (raddr_b == AW'(i)) begin
                stored_b = words[i];
            end
            if (inc_addr == AW'(i)) begin
                inc_old = words[i];
            end
            if (waddr == AW'(i)) begin
                old_w = words[i];
            end
        end
    end

    // A write only counts for forwarding if it would actually land in a
    // real, writable register.
    always_comb begin
        write_ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (waddr == AW'(i) && !(ZERO_REG != 0 && i == 0)) begin
                write_ok = 1'b1;
            end
        end
    end

    // Byte mask used to build the forwarded value from old and new bytes.
    always_comb begin
        be_mask = '0;
        for (int b = 0; b < LANES; b++) begin
            be_mask[8*b +: 8] = {8{wbe[b]}};
        end
    end

    assign merged = (wdata & be_mask) | (old_w & ~be_mask);

    // Forwarding is suppressed during reset so every output reads zero
    // while the bank is held clear.
    assign bypass_a = (BYPASS != 0) && rst_n && we && write_ok && (raddr_a == waddr);
    assign bypass_b = (BYPASS != 0) && rst_n && we && write_ok && (raddr_b == waddr);

    assign rdata_a = bypass_a ? merged : stored_a;
    assign rdata_b = bypass_b ? merged : stored_b;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a vector table on the default
// configuration, then hand-written sequences for asynchronous reset, the
// no-bypass variant and the hardwired-zero / short-depth variant.
module tb_register_file;
    import register_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  wbe;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic        inc_en;
    logic [2:0]  inc_addr;
    logic        inc_down;

    logic [15:0] rdata_a_d, rdata_b_d, inc_old_d;
    logic [15:0] rdata_a_n, rdata_b_n, inc_old_n;
    logic [15:0] rdata_a_z, rdata_b_z, inc_old_z;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [1:0]  wbe;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        inc_en;
        logic [2:0]  inc_addr;
        logic        inc_down;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [15:0] exp_old;
    } vec_t;

    vec_t vecs [25];

    always #5 clk = ~clk;

    // Default configuration: bypass on, no zero register, depth 8.
    register_file dut_d (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .rdata_a(rdata_a_d), .raddr_b(raddr_b), .rdata_b(rdata_b_d),
        .inc_en(inc_en), .inc_addr(inc_addr), .inc_down(inc_down), .inc_old(inc_old_d)
    );

    // Same bank with forwarding disabled.
    register_file #(.BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .rdata_a(rdata_a_n), .raddr_b(raddr_b), .rdata_b(rdata_b_n),
        .inc_en(inc_en), .inc_addr(inc_addr), .inc_down(inc_down), .inc_old(inc_old_n)
    );

    // Hardwired zero register and only six real registers.
    register_file #(.ZERO_REG(1), .DEPTH(6)) dut_z (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .rdata_a(rdata_a_z), .raddr_b(raddr_b), .rdata_b(rdata_b_z),
        .inc_en(inc_en), .inc_addr(inc_addr), .inc_down(inc_down), .inc_old(inc_old_z)
    );

    task automatic applyStimulus(input vec_t v);
        we       = v.we;
        waddr    = v.waddr;
        wdata    = v.wdata;
        wbe      = v.wbe;
        raddr_a  = v.ra;
        raddr_b  = v.rb;
        inc_en   = v.inc_en;
        inc_addr = v.inc_addr;
        inc_down = v.inc_down;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idle();
        we = 1'b0; waddr = 3'd0; wdata = 16'h0000; wbe = 2'b00;
        inc_en = 1'b0; inc_addr = 3'd0; inc_down = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        //            we    wa    wdata     wbe    ra    rb    inc   ia    dn    exp_a     exp_b     exp_old
        vecs[0]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd0, 3'd7, 1'b0, 3'd3, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 3'd2, 16'hAAAA, 2'b11, 3'd2, 3'd2, 1'b0, 3'd2, 1'b0, 16'hAAAA, 16'hAAAA, 16'h0000};
        vecs[2]  = '{1'b1, 3'd2, 16'h1234, 2'b01, 3'd2, 3'd3, 1'b0, 3'd2, 1'b0, 16'hAA34, 16'h0000, 16'hAAAA};
        vecs[3]  = '{1'b1, 3'd2, 16'h5600, 2'b10, 3'd2, 3'd2, 1'b0, 3'd2, 1'b0, 16'h5634, 16'h5634, 16'hAA34};
        vecs[4]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd2, 3'd2, 1'b0, 3'd2, 1'b0, 16'h5634, 16'h5634, 16'h5634};
        vecs[5]  = '{1'b1, 3'd5, 16'h0001, 2'b11, 3'd0, 3'd5, 1'b0, 3'd5, 1'b0, 16'h0000, 16'h0001, 16'h0000};
        vecs[6]  = '{1'b1, 3'd5, 16'hBEEF, 2'b11, 3'd5, 3'd2, 1'b0, 3'd5, 1'b0, 16'hBEEF, 16'h5634, 16'h0001};
        vecs[7]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd5, 3'd5, 1'b0, 3'd5, 1'b0, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vecs[8]  = '{1'b1, 3'd7, 16'hFFFF, 2'b11, 3'd7, 3'd5, 1'b0, 3'd7, 1'b0, 16'hFFFF, 16'hBEEF, 16'h0000};
        vecs[9]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd7, 3'd7, 1'b1, 3'd7, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[10] = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd7, 3'd0, 1'b1, 3'd7, 1'b1, 16'h0000, 16'h0000, 16'h0000};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd7, 3'd7, 1'b0, 3'd7, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[12] = '{1'b1, 3'd4, 16'h0010, 2'b11, 3'd4, 3'd4, 1'b0, 3'd4, 1'b0, 16'h0010, 16'h0010, 16'h0000};
        vecs[13] = '{1'b1, 3'd4, 16'h00AB, 2'b01, 3'd4, 3'd1, 1'b1, 3'd4, 1'b0, 16'h00AB, 16'h0000, 16'h0010};
        vecs[14] = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd4, 3'd4, 1'b0, 3'd4, 1'b0, 16'h00AB, 16'h00AB, 16'h00AB};
        vecs[15] = '{1'b1, 3'd6, 16'h0002, 2'b11, 3'd6, 3'd4, 1'b0, 3'd6, 1'b0, 16'h0002, 16'h00AB, 16'h0000};
        vecs[16] = '{1'b1, 3'd4, 16'h00CD, 2'b01, 3'd4, 3'd6, 1'b1, 3'd6, 1'b0, 16'h00CD, 16'h0002, 16'h0002};
        vecs[17] = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd4, 3'd6, 1'b0, 3'd6, 1'b0, 16'h00CD, 16'h0003, 16'h0003};
        vecs[18] = '{1'b1, 3'd4, 16'h00FF, 2'b11, 3'd4, 3'd4, 1'b0, 3'd4, 1'b0, 16'h00FF, 16'h00FF, 16'h00CD};
        vecs[19] = '{1'b1, 3'd4, 16'h0012, 2'b01, 3'd4, 3'd4, 1'b1, 3'd4, 1'b0, 16'h0012, 16'h0012, 16'h00FF};
        vecs[20] = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd4, 3'd4, 1'b0, 3'd4, 1'b0, 16'h0012, 16'h0012, 16'h0012};
        vecs[21] = '{1'b1, 3'd4, 16'h9999, 2'b00, 3'd4, 3'd4, 1'b0, 3'd4, 1'b0, 16'h0012, 16'h0012, 16'h0012};
        vecs[22] = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd4, 3'd4, 1'b0, 3'd4, 1'b0, 16'h0012, 16'h0012, 16'h0012};
        vecs[23] = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd1, 3'd1, 1'b1, 3'd1, 1'b1, 16'h0000, 16'h0000, 16'h0000};
        vecs[24] = '{1'b0, 3'd0, 16'h0000, 2'b00, 3'd1, 3'd1, 1'b0, 3'd1, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};

        rst_n = 1'b0;
        idle();
        raddr_a = 3'd0;
        raddr_b = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table: drive on the falling edge, check pre-edge outputs 1 ns later,
        // and let later vectors read back the state the edge produced.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d rdata_a", i), rdata_a_d, vecs[i].exp_a);
            checkOutput($sformatf("v%0d rdata_b", i), rdata_b_d, vecs[i].exp_b);
            checkOutput($sformatf("v%0d inc_old", i), inc_old_d, vecs[i].exp_old);
        end

        // Asynchronous reset between edges, and writes ignored while held.
        @(negedge clk);
        idle();
        we = 1'b1; waddr = REG_C; wdata = 16'h1234; wbe = 2'b11;
        raddr_a = REG_C; raddr_b = REG_B; inc_addr = REG_C;
        @(negedge clk);
        we = 1'b0;
        #1;
        checkOutput("r3 before reset", rdata_a_d, 16'h1234);
        checkOutput("r2 before reset", rdata_b_d, 16'h5634);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("r3 async clear", rdata_a_d, 16'h0000);
        checkOutput("r2 async clear", rdata_b_d, 16'h0000);
        checkOutput("inc_old in reset", inc_old_d, 16'h0000);
        we = 1'b1; waddr = REG_C; wdata = 16'h7777; wbe = 2'b11;
        #1;
        checkOutput("bypass in reset", rdata_a_d, 16'h0000);
        @(negedge clk);
        we = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        checkOutput("write ignored in reset", rdata_a_d, 16'h0000);
        @(negedge clk);
        #1;
        checkOutput("r3 after release", rdata_a_d, 16'h0000);

        // Forwarding on versus off.
        @(negedge clk);
        idle();
        we = 1'b1; waddr = REG_BP; wdata = 16'h0001; wbe = 2'b11;
        raddr_a = REG_BP;
        @(negedge clk);
        wdata = 16'hBEEF;
        #1;
        checkOutput("nobypass old value", rdata_a_n, 16'h0001);
        checkOutput("bypass new value", rdata_a_d, 16'hBEEF);
        @(negedge clk);
        we = 1'b0;
        #1;
        checkOutput("nobypass after edge", rdata_a_n, 16'hBEEF);

        // Hardwired zero register and out-of-range address on the short bank.
        @(negedge clk);
        idle();
        we = 1'b1; waddr = REG_A; wdata = 16'h1111; wbe = 2'b11;
        @(negedge clk);
        waddr = REG_ZERO; wdata = 16'h5555; raddr_a = REG_ZERO;
        #1;
        checkOutput("zero reg bypass", rdata_a_z, 16'h0000);
        @(negedge clk);
        waddr = REG_IX; raddr_a = REG_IX;
        #1;
        checkOutput("out of range bypass", rdata_a_z, 16'h0000);
        @(negedge clk);
        we = 1'b0; inc_en = 1'b1; inc_addr = REG_ZERO; inc_down = 1'b0;
        raddr_a = REG_ZERO; raddr_b = REG_IX;
        #1;
        checkOutput("zero reg read", rdata_a_z, 16'h0000);
        checkOutput("out of range read", rdata_b_z, 16'h0000);
        checkOutput("zero reg inc_old", inc_old_z, 16'h0000);
        checkOutput("full bank r6 written", rdata_b_d, 16'h5555);
        @(negedge clk);
        inc_addr = REG_IX; raddr_a = REG_A; raddr_b = REG_BP;
        #1;
        checkOutput("r1 unchanged", rdata_a_z, 16'h1111);
        checkOutput("r5 unchanged", rdata_b_z, 16'hBEEF);
        checkOutput("out of range inc_old", inc_old_z, 16'h0000);
        @(negedge clk);
        inc_en = 1'b0; raddr_a = REG_ZERO; raddr_b = REG_IX;
        #1;
        checkOutput("zero reg after inc", rdata_a_z, 16'h0000);
        checkOutput("out of range after inc", rdata_b_z, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Parametrised successor to the single 16-bit latch register.
- Bank of DEPTH words of WIDTH bits, clocked by one edge instead of a W strobe.
- One write port with byte enables, two read ports with optional same-cycle write bypass, and an increment/decrement port for pointer registers such as SP or an index register.
- Sits in the CPU datapath and feeds the ALU operand buses and the address unit.

Parameters:
WIDTH, 16, data width in bits; must be a multiple of 8
DEPTH, 8, number of registers; need not be a power of two
AW, 3, address width; must satisfy 2^AW >= DEPTH
ZERO_REG, 0, when 1, register 0 is hardwired to zero
BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports
STEP, 1, magnitude added or subtracted by the increment port

Ports:
CLK  input  1  clock; all state changes on rising edge
RST_N  input  1  asynchronous, active-low reset
WE  input  1  write enable
WADDR  input  AW  write address
WDATA  input  WIDTH  write data
WBE  input  WIDTH/8  byte enables; bit i covers WDATA[8i+7:8i]
RADDR_A  input  AW  read address, port A
RDATA_A  output  WIDTH  read data, port A
RADDR_B  input  AW  read address, port B
RDATA_B  output  WIDTH  read data, port B
INC_EN  input  1  increment/decrement enable
INC_ADDR  input  AW  target register for increment/decrement
INC_DOWN  input  1  0 = add STEP, 1 = subtract STEP
INC_OLD  output  WIDTH  pre-update value of register INC_ADDR (combinational)

Behaviour:
- Reset:
  - RST_N low clears every register to 0 immediately, independent of CLK.
  - While RST_N is low, all writes and increments are ignored.
  - With stable addresses, all outputs read 0 during reset.
  - Deassertion is not synchronised inside the block.
- Write:
  - On a rising CLK with WE=1, register WADDR takes WDATA for each byte where WBE is 1.
  - Bytes with WBE=0 keep their old value.
  - Latency: the stored value is visible on the read ports from the edge onward.
- Read:
  - Combinational: RDATA_x = reg[RADDR_x].
  - If BYPASS=1, WE=1 and WADDR==RADDR_x, RDATA_x shows the merged value (enabled WDATA bytes plus old bytes) in the same cycle.
  - If BYPASS=0, RDATA_x shows the old value until the edge.
- Increment port:
  - On a rising CLK with INC_EN=1, reg[INC_ADDR] <= reg[INC_ADDR] +/- STEP, modulo 2^WIDTH.
  - Wrap-around: 0xFFFF+1 -> 0x0000 and 0x0000-1 -> 0xFFFF, with no flag.
  - INC_OLD always shows the current stored value of INC_ADDR, without bypass.
  - Bypass forwards only WE writes, never increment results.
- Simultaneous events:
  - WE and INC_EN on the same address in the same cycle: the write wins for enabled bytes. The increment result is discarded entirely, including for bytes whose WBE is 0.
  - WE and INC_EN on different addresses: both take effect.
  - Both read ports may address the same register.
- ZERO_REG=1:
  - Register 0 reads 0 on every read port and on INC_OLD.
  - Writes and increments to address 0 are ignored; bypass to address 0 yields 0.
- Out of range (address >= DEPTH):
  - Writes and increments are ignored.
  - Reads and INC_OLD return 0.
- WE with WBE all 0 is a no-op.
- No X propagation from unused address bits.

Decomposition:
- Shared package (cpu_pkg):
  - default WIDTH/DEPTH/AW constants
  - byte-lane count function WIDTH/8
  - register index names (REG_SP, REG_IX, etc.) used by decode and address unit
- One natural sub-module, register_word, holding one storage word and instantiated DEPTH times. It contains:
  - async reset
  - per-byte write mux
  - +/- STEP adder
  - write-over-increment priority
- Read muxes, bypass and range checks stay in register_file.

Test Plan:
1. Reset: write 0x1234 to r3, pulse RST_N low mid-cycle with no CLK edge -> RDATA_A (RADDR_A=3) reads 0x0000 immediately; after release it stays 0x0000.
2. Byte enables: r2=0xAAAA, write WDATA=0x1234 with WBE=01 -> r2=0xAA34; then WBE=10 with 0x5600 -> 0x5634.
3. Bypass: BYPASS=1, r5=0x0001, WE=1, WADDR=5, WDATA=0xBEEF, RADDR_A=5 before the edge -> RDATA_A=0xBEEF in the same cycle. With BYPASS=0 -> 0x0001 until the edge.
4. Increment wrap: r7=0xFFFF, INC_EN=1, INC_DOWN=0 -> 0x0000 and INC_OLD=0xFFFF before the edge. Then INC_DOWN=1 -> 0xFFFF.
5. Collision: r4=0x0010, same cycle WE (WBE=01, 0x00AB) and INC_EN on r4 -> r4=0x00AB, increment lost. Repeat with INC_ADDR=6, r6=0x0002 -> r4 written and r6=0x0003.
6. ZERO_REG=1, DEPTH=6: write 0x5555 to r0 and to r6 -> RDATA at addresses 0 and 6 both read 0x0000; other registers are unchanged.
